// File: rtl/systolic_result_collector_if.sv
// Result stream from the systolic collector: row-major elements over valid/ready.
interface systolic_result_collector_if #(
  parameter int ACC_WIDTH = 10
);
  logic [ACC_WIDTH-1:0] data;
  logic [3:0]           index;
  logic                 valid;
  logic                 last;
  logic                 ready;

  modport master (output data, output index, output valid, output last, input ready);
  modport slave  (input data, input index, input valid, input last, output ready);
endinterface

// File: rtl/systolic_result_collector.sv
// Waits a fixed drain time after the feeder starts, snapshots the 3x3 accumulator array,
// streams it row-major over valid/ready, then pulses DONE and ACC_CLEAR together.
//
//  state  | meaning
//  S_IDLE | waiting for START
//  S_WAIT | draining the array; down-counter runs to the snapshot edge
//  S_SEND | streaming the nine buffered results
//  S_DONE | single cycle with DONE and ACC_CLEAR high
module systolic_result_collector #(
  parameter int WIDTH        = 4,
  parameter int ACC_WIDTH    = 2*WIDTH + 2,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start_i,
  input  logic [9*ACC_WIDTH-1:0] c_in_i,
  systolic_result_collector_if.master out_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   acc_clear_o
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [9*ACC_WIDTH-1:0] buf_q, buf_d;
  logic [ACC_WIDTH-1:0]   data_q, data_d;
  logic [3:0]             idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   clr_q, clr_d;
  logic [3:0]             idx_inc;

  assign idx_inc = idx_q + 4'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      S_WAIT: begin
        // Terminal count lands exactly DRAIN_CYCLES edges after START was taken.
        if (cnt_q == '0) begin
          buf_d   = c_in_i;
          state_d = S_SEND;
          valid_d = 1'b1;
          idx_d   = 4'd0;
          data_d  = c_in_i[ACC_WIDTH-1:0];
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SEND: begin
        if (valid_q && out_if.ready) begin
          if (idx_q == 4'd8) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_DONE;
            done_d  = 1'b1;
            clr_d   = 1'b1;
          end else begin
            idx_d  = idx_inc;
            data_d = buf_q[idx_inc*ACC_WIDTH +: ACC_WIDTH];
            last_d = (idx_inc == 4'd8);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign out_if.data  = data_q;
  assign out_if.index = idx_q;
  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign acc_clear_o  = clr_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed-plus-random bench for the result collector; the expected stream is the matrix
// product computed here, snapshotted DRAIN_CYCLES edges after START.
module tb_systolic_result_collector;
  localparam int AW    = 10;
  localparam int DRAIN = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [9*AW-1:0] c_in = '0;
  logic          busy, done, clr;
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_c [9];
  int            ma [3][3];
  int            mb [3][3];
  logic [9*AW-1:0] snap;

  systolic_result_collector_if #(.ACC_WIDTH(AW)) bus ();

  systolic_result_collector #(.WIDTH(4), .ACC_WIDTH(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK(CLK), .RST(RST), .start_i(start), .c_in_i(c_in),
    .out_if(bus.master), .busy_o(busy), .done_o(done), .acc_clear_o(clr)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [9*AW-1:0] rand_mat();
    logic [9*AW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*AW +: AW] = AW'($urandom_range(0, 1023));
    return v;
  endfunction

  task automatic matmul;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_c[r*3+c] = 0;
        for (int k = 0; k < 3; k++) exp_c[r*3+c] += ma[r][k] * mb[k][c];
      end
    for (int i = 0; i < 9; i++) snap[i*AW +: AW] = AW'(exp_c[i]);
  endtask

  // mode 0: ready always, 1: 1,0,0 repeating, 2: random. abort_at >= 0 resets after that many transfers.
  task automatic run_txn(input int mode, input bit noise, input int abort_at);
    int n;
    int cyc;
    logic r;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("valid_after_start", 32'(bus.valid), 0);
    for (int e = 1; e <= DRAIN; e++) begin
      c_in = (e == DRAIN) ? snap : rand_mat();
      if (noise && e == 2) start = 1'b1;
      tick;
      start = 1'b0;
      if (e < DRAIN) chk("valid_in_wait", 32'(bus.valid), 0);
    end
    c_in = rand_mat();
    n = 0;
    cyc = 0;
    while (n < 9 && cyc < 200) begin
      if (abort_at >= 0 && n == abort_at) break;
      chk("valid", 32'(bus.valid), 1);
      chk("index", 32'(bus.index), 32'(n));
      chk("data", 32'(bus.data), 32'(exp_c[n]));
      chk("last", 32'(bus.last), 32'(n == 8));
      chk("done_low_in_send", 32'(done), 0);
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.ready = r;
      if (noise && cyc == 3) start = 1'b1;
      c_in = rand_mat();
      tick;
      start = 1'b0;
      if (r) n++;
      cyc++;
    end
    if (abort_at >= 0) begin
      RST = 1'b0;
      #2;
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_index", 32'(bus.index), 0);
      chk("rst_data", 32'(bus.data), 0);
      chk("rst_last", 32'(bus.last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_clr", 32'(clr), 0);
      tick;
      RST = 1'b1;
      tick;
      chk("no_done_after_abort", 32'(done), 0);
      return;
    end
    chk("stream_within_budget", 32'(cyc < 200), 1);
    if (mode == 0) chk("full_throughput_cycles", 32'(cyc), 9);
    chk("done_pulse", 32'(done), 1);
    chk("clr_pulse", 32'(clr), 1);
    chk("valid_after_last", 32'(bus.valid), 0);
    chk("last_after_last", 32'(bus.last), 0);
    chk("busy_in_done", 32'(busy), 1);
    bus.ready = 1'b0;
    tick;
    chk("done_one_cycle", 32'(done), 0);
    chk("clr_one_cycle", 32'(clr), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("valid_idle", 32'(bus.valid), 0);
  endtask

  initial begin
    bus.ready = 1'b0;
    tick;
    chk("reset_valid", 32'(bus.valid), 0);
    chk("reset_index", 32'(bus.index), 0);
    chk("reset_data", 32'(bus.data), 0);
    chk("reset_last", 32'(bus.last), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_clr", 32'(clr), 0);
    RST = 1'b1;
    tick;

    // A = identity, B = 1..9
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r*3 + c + 1;
      end
    matmul();
    run_txn(0, 1'b0, -1);
    run_txn(1, 1'b0, -1);

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = $urandom_range(0, 15);
        mb[r][c] = $urandom_range(0, 15);
      end
    matmul();
    run_txn(2, 1'b0, -1);
    run_txn(0, 1'b1, -1);
    run_txn(0, 1'b0, 4);

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 15;
        mb[r][c] = $urandom_range(0, 15);
      end
    matmul();
    run_txn(0, 1'b0, -1);

    for (int i = 0; i < 9; i++) exp_c[i] = 1023;
    for (int i = 0; i < 9; i++) snap[i*AW +: AW] = AW'(exp_c[i]);
    run_txn(0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
